wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file write port.
- Merges ALU results and load-unit responses into one registered rd write per cycle.
- Sign/zero-extends and aligns load data, and buffers loads in a small FIFO when the ALU holds the port.
- Outputs drive the register file's write enable, rd address and rd data inputs.

Parameters:
XLEN, 32, datapath width
LQ_DEPTH, 2, load buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
alu_valid_i  input  1  ALU result valid
alu_ready_o  output  1  ALU result accepted this cycle
alu_rd_i  input  5  ALU destination register
alu_data_i  input  XLEN  ALU result
ld_valid_i  input  1  load response valid
ld_ready_o  output  1  load response accepted this cycle
ld_rd_i  input  5  load destination register
ld_funct3_i  input  3  load type (RV32I funct3)
ld_addr_lo_i  input  2  load byte address [1:0]
ld_data_i  input  XLEN  raw aligned memory word
wr_en_o  output  1  register file write enable
rd_addr_o  output  5  register file write address
rd_data_o  output  XLEN  register file write data
ld_count_o  output  $clog2(LQ_DEPTH)+1  buffered load count

Behaviour:
- Reset: asynchronous, active-high, on clk/rst edge.
  - While rst=1: wr_en_o=0, rd_addr_o=0, rd_data_o=0, buffer emptied (pointers and count 0), ld_count_o=0, alu_ready_o=0, ld_ready_o=0.
  - Reset mid-operation discards buffered loads with no write.
- Handshakes: valid/ready; a transfer occurs when both are high at a posedge. Upstream holds payload stable while valid && !ready.
- Readiness (combinational, rst=0):
  - ld_ready_o = (count < LQ_DEPTH); no push on a full buffer even if popping.
  - alu_ready_o = (count != LQ_DEPTH).
- Load extension, applied combinationally before the buffer:
  - 000 LB: byte ld_addr_lo_i, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword ld_addr_lo_i[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW and all other codes: full word, offset ignored.
- Arbitration, evaluated each cycle from current state:
  - 1. Buffer full: pop oldest load to output; ALU not accepted.
  - 2. Else if alu_valid_i: accept ALU, ALU result to output; an accepted load is pushed.
  - 3. Else if buffer non-empty: pop oldest load to output; an accepted load is pushed.
  - 4. Else if load accepted (buffer empty): bypass directly to output, no push.
  - 5. Else: no write.
- Simultaneous push and pop on a non-full buffer: count unchanged, FIFO order preserved.
- Output register:
  - Selection in cycle N appears on wr_en_o/rd_addr_o/rd_data_o in cycle N+1 for exactly one cycle.
  - With no selection, wr_en_o=0; rd_addr_o/rd_data_o hold their previous values.
- rd=0: the selected item is consumed normally (handshake, pop), but wr_en_o stays 0 for it.
- Latency:
  - ALU: 1 cycle.
  - Load, unblocked: 1 cycle (bypass).
  - Load, buffered: 1 cycle after it is popped.
- Ordering: loads leave in acceptance order. ALU and load results are not mutually ordered; the upstream hazard logic guarantees no same-rd conflict in flight.
- ld_count_o reflects the registered count. Pointers wrap modulo LQ_DEPTH.

Test Plan:
- Reset: assert rst mid-burst with 2 loads buffered -> outputs 0 immediately, readies 0; after release ld_count_o=0 and no stale write appears.
- ALU only: alu_valid_i=1, rd=5, data=0xDEADBEEF -> next cycle wr_en_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF.
  - Same stimulus with rd=0 -> alu_ready_o=1 and wr_en_o=0.
- Load extension: ld_data_i=0x80FF7F01.
  - LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
  - LW -> 0x80FF7F01; funct3=011 -> 0x80FF7F01.
  - Each load with an empty buffer and no ALU is written 1 cycle later.
- Contention: ALU valid every cycle plus loads to x1, x2, x3 back-to-back.
  - x1 and x2 are buffered and ld_count_o reaches 2 (LQ_DEPTH=2).
  - ld_ready_o drops while x3 is held.
  - alu_ready_o=0 for one cycle while x1 is written.
  - x1 is written before x2, and x3 is accepted after.
- Simultaneous push/pop: count=1, no ALU, load accepted -> oldest written, new load enqueued, ld_count_o stays 1, FIFO order preserved.
- Random soak: 10k cycles of random valid/ready traffic -> the writeback sequence matches a scoreboard model; no lost or duplicated writes; no write ever has rd_addr_o=0.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  wb_stage : writeback merge of ALU results and extended loads into one
//             registered register-file write per cycle.   Rev 1.0
// ============================================================================
module wb_stage #(
   parameter int XLEN     = 32,
   parameter int LQ_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_valid_i,
   output logic                        alu_ready_o,
   input  logic [4:0]                  alu_rd_i,
   input  logic [XLEN-1:0]             alu_data_i,
   input  logic                        ld_valid_i,
   output logic                        ld_ready_o,
   input  logic [4:0]                  ld_rd_i,
   input  logic [2:0]                  ld_funct3_i,
   input  logic [1:0]                  ld_addr_lo_i,
   input  logic [XLEN-1:0]             ld_data_i,
   output logic                        wr_en_o,
   output logic [4:0]                  rd_addr_o,
   output logic [XLEN-1:0]             rd_data_o,
   output logic [$clog2(LQ_DEPTH):0]   ld_count_o
);

   localparam int c_ptr_w = $clog2(LQ_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(LQ_DEPTH);

   logic [c_cnt_w-1:0] r_count;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [4:0]         r_q_rd   [LQ_DEPTH];
   logic [XLEN-1:0]    r_q_data [LQ_DEPTH];
   logic               r_wr_en;
   logic [4:0]         r_rd_addr;
   logic [XLEN-1:0]    r_rd_data;

   logic               w_full;
   logic               w_empty;
   logic               w_ld_acc;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [XLEN-1:0]    w_ld_ext;
   logic               w_sel_valid;
   logic [4:0]         w_sel_rd;
   logic [XLEN-1:0]    w_sel_data;
   logic               w_push;
   logic               w_pop;

   assign w_full      = (r_count == c_full);
   assign w_empty     = (r_count == '0);
   assign ld_ready_o  = !rst && (r_count < c_full);
   assign alu_ready_o = !rst && !w_full;
   assign w_ld_acc    = ld_valid_i && ld_ready_o;

   assign w_byte = ld_data_i[{ld_addr_lo_i, 3'b000} +: 8];
   assign w_half = ld_data_i[{ld_addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      w_ld_ext = ld_data_i;
      case (ld_funct3_i)
         3'b000:  w_ld_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b100:  w_ld_ext = {{(XLEN-8){1'b0}}, w_byte};
         3'b001:  w_ld_ext = {{(XLEN-16){w_half[15]}}, w_half};
         3'b101:  w_ld_ext = {{(XLEN-16){1'b0}}, w_half};
         default: w_ld_ext = ld_data_i;
      endcase
   end

   // A full buffer always drains first; otherwise the ALU owns the port and
   // loads queue behind it, with an empty buffer letting a load bypass.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_rd    = 5'd0;
      w_sel_data  = '0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      if (w_full) begin
         w_pop       = 1'b1;
         w_sel_valid = 1'b1;
         w_sel_rd    = r_q_rd[r_rd_ptr];
         w_sel_data  = r_q_data[r_rd_ptr];
      end else if (alu_valid_i) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = alu_rd_i;
         w_sel_data  = alu_data_i;
         w_push      = w_ld_acc;
      end else if (!w_empty) begin
         w_pop       = 1'b1;
         w_sel_valid = 1'b1;
         w_sel_rd    = r_q_rd[r_rd_ptr];
         w_sel_data  = r_q_data[r_rd_ptr];
         w_push      = w_ld_acc;
      end else if (w_ld_acc) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = ld_rd_i;
         w_sel_data  = w_ld_ext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_wr_en   <= 1'b0;
         r_rd_addr <= 5'd0;
         r_rd_data <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
         // x0 writes are consumed but never asserted to the register file.
         r_wr_en <= w_sel_valid && (w_sel_rd != 5'd0);
         if (w_sel_valid) begin
            r_rd_addr <= w_sel_rd;
            r_rd_data <= w_sel_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_rd[r_wr_ptr]   <= ld_rd_i;
         r_q_data[r_wr_ptr] <= w_ld_ext;
      end
   end

   assign wr_en_o    = r_wr_en;
   assign rd_addr_o  = r_rd_addr;
   assign rd_data_o  = r_rd_data;
   assign ld_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  tb_wb_stage : directed and random traffic against a queue-based writeback
//                model, checked every cycle.   Rev 1.0
// ============================================================================
module tb_wb_stage;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid_i, alu_ready_o, ld_valid_i, ld_ready_o, wr_en_o;
   logic [4:0]  alu_rd_i, ld_rd_i, rd_addr_o;
   logic [31:0] alu_data_i, ld_data_i, rd_data_o;
   logic [2:0]  ld_funct3_i;
   logic [1:0]  ld_addr_lo_i;
   logic [1:0]  ld_count_o;

   wb_stage #(.XLEN(XLEN), .LQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
      .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
      .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
      .ld_rd_i(ld_rd_i), .ld_funct3_i(ld_funct3_i),
      .ld_addr_lo_i(ld_addr_lo_i), .ld_data_i(ld_data_i),
      .wr_en_o(wr_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
      .ld_count_o(ld_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {logic [4:0] rd; logic [31:0] d;} wr_t;
   typedef struct {logic [4:0] rd; logic [2:0] f3; logic [1:0] off; logic [31:0] d;} ld_t;

   wr_t  alu_stim[$];
   ld_t  ld_stim[$];
   wr_t  mq[$];
   wr_t  wlog[$];
   int   alu_rate = 100, ld_rate = 100;
   int   checks = 0, errors = 0;
   logic        e_wr = 1'b0;
   logic [4:0]  e_addr = 5'd0;
   logic [31:0] e_data = 32'd0;
   int   mon_max_cnt = 0, mon_ld_block = 0, mon_alu_run = 0, mon_alu_run_max = 0;
   int   pp_hits = 0;
   logic pp_pending = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * int'(off))) & 32'hFF;
      h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
      case (f3)
         3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
         3'b100:  return b;
         3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   // Stimulus driver: holds payload while valid && !ready.
   initial begin : driver
      logic a_acc, l_acc;
      alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
      ld_valid_i = 0; ld_rd_i = 0; ld_funct3_i = 0; ld_addr_lo_i = 0; ld_data_i = 0;
      forever begin
         @(negedge clk);
         a_acc = alu_valid_i && alu_ready_o;
         l_acc = ld_valid_i && ld_ready_o;
         @(posedge clk);
         #1;
         if (rst) begin
            alu_stim.delete(); ld_stim.delete();
            alu_valid_i = 0; ld_valid_i = 0;
         end else begin
            if (a_acc) void'(alu_stim.pop_front());
            if (l_acc) void'(ld_stim.pop_front());
            if (alu_stim.size() == 0) alu_valid_i = 0;
            else if (!alu_valid_i || a_acc) alu_valid_i = ($urandom_range(99) < alu_rate);
            if (ld_stim.size() == 0) ld_valid_i = 0;
            else if (!ld_valid_i || l_acc) ld_valid_i = ($urandom_range(99) < ld_rate);
            if (alu_stim.size() > 0) begin
               alu_rd_i = alu_stim[0].rd; alu_data_i = alu_stim[0].d;
            end
            if (ld_stim.size() > 0) begin
               ld_rd_i = ld_stim[0].rd; ld_funct3_i = ld_stim[0].f3;
               ld_addr_lo_i = ld_stim[0].off; ld_data_i = ld_stim[0].d;
            end
         end
      end
   end

   // Model and per-cycle comparison.
   initial begin : compare
      wr_t  it;
      logic ltx, sel;
      int   n;
      forever begin
         @(negedge clk);
         if (pp_pending) begin
            chk("pushpop_count_held", 32'(ld_count_o), 32'd1);
            pp_pending = 1'b0;
         end
         if (rst) begin
            chk("rst_wr_en", 32'(wr_en_o), 32'd0);
            chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
            chk("rst_rd_data", rd_data_o, 32'd0);
            chk("rst_count", 32'(ld_count_o), 32'd0);
            chk("rst_alu_ready", 32'(alu_ready_o), 32'd0);
            chk("rst_ld_ready", 32'(ld_ready_o), 32'd0);
            mq.delete();
            e_wr = 1'b0; e_addr = 5'd0; e_data = 32'd0;
            continue;
         end
         n = mq.size();
         chk("wr_en", 32'(wr_en_o), 32'(e_wr));
         if (e_wr && wr_en_o) begin
            chk("rd_addr", 32'(rd_addr_o), 32'(e_addr));
            chk("rd_data", rd_data_o, e_data);
         end
         if (wr_en_o) begin
            chk("write_rd_nonzero", 32'(rd_addr_o != 5'd0), 32'd1);
            wlog.push_back('{rd_addr_o, rd_data_o});
         end
         chk("ld_count", 32'(ld_count_o), 32'(n));
         chk("alu_ready", 32'(alu_ready_o), 32'(n != DEPTH));
         chk("ld_ready", 32'(ld_ready_o), 32'(n < DEPTH));
         if (int'(ld_count_o) > mon_max_cnt) mon_max_cnt = int'(ld_count_o);
         if (ld_valid_i && !ld_ready_o) mon_ld_block++;
         if (alu_valid_i && !alu_ready_o) mon_alu_run++; else mon_alu_run = 0;
         if (mon_alu_run > mon_alu_run_max) mon_alu_run_max = mon_alu_run;

         ltx = ld_valid_i && (n < DEPTH);
         sel = 1'b1;
         it  = '{5'd0, 32'd0};
         if (n == DEPTH) begin
            it = mq.pop_front();
         end else if (alu_valid_i) begin
            it = '{alu_rd_i, alu_data_i};
            if (ltx) mq.push_back('{ld_rd_i, ext(ld_funct3_i, ld_addr_lo_i, ld_data_i)});
         end else if (n > 0) begin
            it = mq.pop_front();
            if (ltx) begin
               mq.push_back('{ld_rd_i, ext(ld_funct3_i, ld_addr_lo_i, ld_data_i)});
               if (n == 1) begin pp_pending = 1'b1; pp_hits++; end
            end
         end else if (ltx) begin
            it = '{ld_rd_i, ext(ld_funct3_i, ld_addr_lo_i, ld_data_i)};
         end else begin
            sel = 1'b0;
         end
         if (sel) begin
            e_wr = (it.rd != 5'd0); e_addr = it.rd; e_data = it.d;
         end else begin
            e_wr = 1'b0;
         end
      end
   end

   task automatic wait_idle(input int budget);
      int idle = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (alu_stim.size() == 0 && ld_stim.size() == 0 && !alu_valid_i && !ld_valid_i && ld_count_o == 2'd0)
            idle++;
         else
            idle = 0;
         if (idle >= 3) return;
      end
      checks++; errors++;
      $display("FAIL wait_idle: traffic not drained after %0d cycles", budget);
   endtask

   task automatic expect_write(input string name, input int idx, input logic [4:0] rd, input logic [31:0] d);
      if (idx < wlog.size()) begin
         chk({name, "_rd"}, 32'(wlog[idx].rd), 32'(rd));
         chk({name, "_data"}, wlog[idx].d, d);
      end else begin
         checks++; errors++;
         $display("FAIL %s: write %0d missing, only %0d writes seen", name, idx, wlog.size());
      end
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
      logic [1:0]  offs[6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1};
      logic [31:0] exps[6] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                               32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};
      int n, i1, i2, i3, bad, exp_writes;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      wait_idle(20);

      // ALU writes
      wlog.delete();
      alu_stim.push_back('{5'd5, 32'hDEADBEEF});
      wait_idle(50);
      chk("alu_write_count", 32'(wlog.size()), 32'd1);
      expect_write("alu_x5", 0, 5'd5, 32'hDEADBEEF);

      wlog.delete();
      alu_stim.push_back('{5'd0, 32'hDEADBEEF});
      @(negedge clk);
      chk("alu_rd0_valid", 32'(alu_valid_i), 32'd1);
      chk("alu_rd0_ready", 32'(alu_ready_o), 32'd1);
      wait_idle(50);
      chk("alu_rd0_no_write", 32'(wlog.size()), 32'd0);

      // Load extension, one isolated load at a time
      for (int k = 0; k < 6; k++) begin
         chk("model_ext", ext(f3s[k], offs[k], 32'h80FF7F01), exps[k]);
         wlog.delete();
         ld_stim.push_back('{5'(9 + k), f3s[k], offs[k], 32'h80FF7F01});
         wait_idle(50);
         expect_write("load_ext", 0, 5'(9 + k), exps[k]);
      end

      // Contention: ALU every cycle, loads x1..x3 back to back
      wlog.delete();
      mon_max_cnt = 0; mon_ld_block = 0; mon_alu_run = 0; mon_alu_run_max = 0;
      for (int k = 0; k < 4; k++) alu_stim.push_back('{5'(10 + k), 32'hA000_0000 + 32'(k)});
      for (int k = 1; k <= 3; k++) ld_stim.push_back('{5'(k), 3'b010, 2'd0, 32'h1000_0000 * 32'(k)});
      wait_idle(100);
      chk("cont_max_count", 32'(mon_max_cnt), 32'd2);
      chk("cont_ld_ready_dropped", 32'(mon_ld_block > 0), 32'd1);
      chk("cont_alu_stall_run", 32'(mon_alu_run_max), 32'd1);
      i1 = -1; i2 = -1; i3 = -1;
      foreach (wlog[k]) begin
         if (wlog[k].rd == 5'd1) i1 = k;
         if (wlog[k].rd == 5'd2) i2 = k;
         if (wlog[k].rd == 5'd3) i3 = k;
      end
      chk("cont_x1_before_x2", 32'(i1 >= 0 && i1 < i2), 32'd1);
      chk("cont_x2_before_x3", 32'(i2 >= 0 && i2 < i3), 32'd1);
      chk("cont_write_count", 32'(wlog.size()), 32'd7);
      if (i1 >= 0) expect_write("cont_x1", i1, 5'd1, 32'h1000_0000);

      // Simultaneous push and pop with one entry buffered
      wlog.delete();
      pp_hits = 0;
      alu_stim.push_back('{5'd15, 32'h0000_0F0F});
      ld_stim.push_back('{5'd16, 3'b010, 2'd0, 32'h1111_1111});
      ld_stim.push_back('{5'd17, 3'b100, 2'd2, 32'h2233_4455});
      wait_idle(50);
      chk("pushpop_seen", 32'(pp_hits > 0), 32'd1);
      expect_write("pushpop_alu", 0, 5'd15, 32'h0000_0F0F);
      expect_write("pushpop_old", 1, 5'd16, 32'h1111_1111);
      expect_write("pushpop_new", 2, 5'd17, 32'h0000_0033);

      // Reset with two loads buffered
      wlog.delete();
      for (int k = 0; k < 3; k++) alu_stim.push_back('{5'(20 + k), 32'hB000_0000 + 32'(k)});
      ld_stim.push_back('{5'd7, 3'b010, 2'd0, 32'h7777_7777});
      ld_stim.push_back('{5'd8, 3'b010, 2'd0, 32'h8888_8888});
      n = 0;
      do begin @(negedge clk); n++; end while (ld_count_o != 2'd2 && n < 20);
      chk("rst_pre_count", 32'(ld_count_o), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_wr_en", 32'(wr_en_o), 32'd0);
      chk("rst_async_rd_addr", 32'(rd_addr_o), 32'd0);
      chk("rst_async_rd_data", rd_data_o, 32'd0);
      chk("rst_async_count", 32'(ld_count_o), 32'd0);
      chk("rst_async_alu_ready", 32'(alu_ready_o), 32'd0);
      chk("rst_async_ld_ready", 32'(ld_ready_o), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_post_count", 32'(ld_count_o), 32'd0);
      chk("rst_post_wr_en", 32'(wr_en_o), 32'd0);
      wait_idle(50);
      bad = 0;
      foreach (wlog[k]) if (wlog[k].rd == 5'd7 || wlog[k].rd == 5'd8) bad++;
      chk("rst_no_stale_load", 32'(bad), 32'd0);

      // Random soak
      wlog.delete();
      exp_writes = 0;
      alu_rate = 70; ld_rate = 70;
      for (int k = 0; k < 4000; k++) begin
         wr_t a;
         ld_t l;
         a.rd = 5'($urandom_range(31)); a.d = $urandom;
         l.rd = 5'($urandom_range(31)); l.f3 = 3'($urandom_range(7));
         l.off = 2'($urandom_range(3)); l.d = $urandom;
         alu_stim.push_back(a);
         ld_stim.push_back(l);
         if (a.rd != 5'd0) exp_writes++;
         if (l.rd != 5'd0) exp_writes++;
      end
      wait_idle(40000);
      chk("soak_write_count", 32'(wlog.size()), 32'(exp_writes));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
